// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 8-bit accumulator CPU.
// Holds the PC, drives the combinational ROM address and captures the returned
// byte into an instruction register.
// The IR is offered to the decoder over a valid/ready handshake.
// Branch redirects from execute reload the PC and discard the IR.
// Optional feature macro: FETCH_HALT_EN
//   - Opcode 4'hF stops fetching in a HALT state.
//   - A later branch resumes fetching.
//   - Without the macro, 4'hF is an ordinary instruction and halted is tied 0.
module fetch_stage #(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [3:0]        ir_opcode,
    output logic [3:0]        ir_operand,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted
);

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [DATA_W-1:0]  ir;
    logic [ADDR_W-1:0]  ir_pc_q;
    logic               ir_valid_q;
    logic               load;

    // The ROM is read combinationally at the current PC.
    assign rom_addr   = pc;
    assign ir_opcode  = ir[DATA_W-1 -: 4];
    assign ir_operand = ir[3:0];
    assign ir_pc      = ir_pc_q;
    assign ir_valid   = ir_valid_q;

    // Refill when the IR is empty or being consumed.
    // A branch in the same cycle wins over the refill.
    assign load = (!ir_valid_q || ir_ready) && !br_valid;

`ifdef FETCH_HALT_EN
    logic halted_q;
    logic is_halt;
    assign is_halt = (rom_data[DATA_W-1 -: 4] == 4'hF);
    assign halted  = halted_q;
`else
    assign halted  = 1'b0;
`endif

    // Fetch control FSM with PC, IR and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Branches are ignored here; only start leaves IDLE.
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (br_valid) begin
                        // Redirect and drop whatever is in the IR, consumed or not.
                        pc         <= br_target;
                        ir_valid_q <= 1'b0;
                    end else if (load) begin
`ifdef FETCH_HALT_EN
                        if (is_halt) begin
                            // HALT never enters the IR.
                            // The PC stays pointing at the HALT instruction.
                            ir_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                            state      <= HALT;
                        end else
`endif
                        begin
                            ir         <= rom_data;
                            ir_pc_q    <= pc;
                            pc         <= pc + ADDR_W'(1);
                            ir_valid_q <= 1'b1;
                        end
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    // A branch from an older in-flight instruction resumes fetching.
                    if (br_valid) begin
                        pc         <= br_target;
                        ir_valid_q <= 1'b0;
                        halted_q   <= 1'b0;
                        state      <= RUN;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector bench for fetch_stage.
// The ROM is a local array read at rom_addr.
module tb_fetch_stage;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] ir_opcode;
    logic [3:0] ir_operand;
    logic [7:0] ir_pc;
    logic       ir_valid;
    logic       ir_ready;
    logic       br_valid;
    logic [7:0] br_target;
    logic       halted;

    logic [7:0] rom [256];

    int checks;
    int failures;

    fetch_stage #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .halted     (halted)
    );

    assign rom_data = rom[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full IR presentation in one call.
    task automatic check_ir(input string tag, input logic [7:0] ir, input logic [7:0] pc_of,
                            input logic [7:0] next_addr);
        check({tag, ".valid"},   {31'd0, ir_valid}, 32'd1);
        check({tag, ".opcode"},  {28'd0, ir_opcode}, {28'd0, ir[7:4]});
        check({tag, ".operand"}, {28'd0, ir_operand}, {28'd0, ir[3:0]});
        check({tag, ".ir_pc"},   {24'd0, ir_pc}, {24'd0, pc_of});
        check({tag, ".addr"},    {24'd0, rom_addr}, {24'd0, next_addr});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        rom[0]    = 8'h6F;
        rom[1]    = 8'h41;
        rom[2]    = 8'h80;
        rom[3]    = 8'h33;
        rom[8'hFF] = 8'h00;

        rst_n     = 1'b0;
        start     = 1'b0;
        ir_ready  = 1'b0;
        br_valid  = 1'b0;
        br_target = 8'h00;

        // Reset state
        #3;
        check("rst.valid",  {31'd0, ir_valid}, 32'd0);
        check("rst.addr",   {24'd0, rom_addr}, 32'h00);
        check("rst.opcode", {28'd0, ir_opcode}, 32'd0);
        check("rst.ir_pc",  {24'd0, ir_pc}, 32'd0);
        check("rst.halted", {31'd0, halted}, 32'd0);
        #9;
        rst_n = 1'b1;

        // IDLE ignores branches and does not fetch
        br_valid  = 1'b1;
        br_target = 8'h55;
        ir_ready  = 1'b1;
        tick();
        check("idle.valid", {31'd0, ir_valid}, 32'd0);
        check("idle.addr",  {24'd0, rom_addr}, 32'h00);

        // Start: ir_valid rises two edges later
        br_valid = 1'b0;
        start    = 1'b1;
        tick();
        check("start.e1.valid", {31'd0, ir_valid}, 32'd0);
        check("start.e1.addr",  {24'd0, rom_addr}, 32'h00);
        tick();
        check_ir("fetch0", 8'h6F, 8'h00, 8'h01);
        tick();
        check_ir("fetch1", 8'h41, 8'h01, 8'h02);

        // Stall for three cycles on 41
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ir("stall", 8'h41, 8'h01, 8'h02);
        end
        ir_ready = 1'b1;
        tick();
        check_ir("release", 8'h80, 8'h02, 8'h03);

        // Branch to 01 with ir_ready high
        br_valid  = 1'b1;
        br_target = 8'h01;
        tick();
        check("br.valid", {31'd0, ir_valid}, 32'd0);
        check("br.addr",  {24'd0, rom_addr}, 32'h01);
        br_valid = 1'b0;
        tick();
        check_ir("br.tgt", 8'h41, 8'h01, 8'h02);

        // Wrap through FF
        br_valid  = 1'b1;
        br_target = 8'hFF;
        tick();
        check("wrap.valid", {31'd0, ir_valid}, 32'd0);
        check("wrap.addr",  {24'd0, rom_addr}, 32'hFF);
        br_valid = 1'b0;
        tick();
        check_ir("wrap.ff", 8'h00, 8'hFF, 8'h00);
        tick();
        check_ir("wrap.00", 8'h6F, 8'h00, 8'h01);

        // Branch wins over a stall
        ir_ready  = 1'b0;
        br_valid  = 1'b1;
        br_target = 8'h03;
        tick();
        check("brstall.valid", {31'd0, ir_valid}, 32'd0);
        check("brstall.addr",  {24'd0, rom_addr}, 32'h03);
        br_valid = 1'b0;
        tick();
        check_ir("brstall.load", 8'h33, 8'h03, 8'h04);
        tick();
        check_ir("brstall.hold", 8'h33, 8'h03, 8'h04);

        // Asynchronous reset in the middle of a stall
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid",  {31'd0, ir_valid}, 32'd0);
        check("arst.addr",   {24'd0, rom_addr}, 32'h00);
        check("arst.opcode", {28'd0, ir_opcode}, 32'd0);
        check("arst.ir_pc",  {24'd0, ir_pc}, 32'd0);
        start = 1'b0;
        tick();
        #2;
        rst_n    = 1'b1;
        ir_ready = 1'b1;
        tick();
        check("arst.idle.valid", {31'd0, ir_valid}, 32'd0);
        check("arst.idle.addr",  {24'd0, rom_addr}, 32'h00);

        // Opcode F handling
        rom[1] = 8'h80;
        rom[2] = 8'hF0;
        start  = 1'b1;
        tick();
        tick();
        check_ir("f.fetch0", 8'h6F, 8'h00, 8'h01);
        tick();
        check_ir("f.fetch1", 8'h80, 8'h01, 8'h02);
        tick();
`ifdef FETCH_HALT_EN
        check("halt.halted", {31'd0, halted}, 32'd1);
        check("halt.valid",  {31'd0, ir_valid}, 32'd0);
        check("halt.addr",   {24'd0, rom_addr}, 32'h02);
        tick();
        check("halt.hold.halted", {31'd0, halted}, 32'd1);
        check("halt.hold.valid",  {31'd0, ir_valid}, 32'd0);
        check("halt.hold.addr",   {24'd0, rom_addr}, 32'h02);
        br_valid  = 1'b1;
        br_target = 8'h00;
        tick();
        check("resume.halted", {31'd0, halted}, 32'd0);
        check("resume.valid",  {31'd0, ir_valid}, 32'd0);
        check("resume.addr",   {24'd0, rom_addr}, 32'h00);
        br_valid = 1'b0;
        tick();
        check_ir("resume.fetch", 8'h6F, 8'h00, 8'h01);
`else
        check_ir("f.plain", 8'hF0, 8'h02, 8'h03);
        check("f.halted", {31'd0, halted}, 32'd0);
        tick();
        check_ir("f.after", 8'h33, 8'h03, 8'h04);
        check("f.after.halted", {31'd0, halted}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
